// File: rtl/lenet_loader_pkg.sv
// Shared types and default sizing for the LeNet frame loader.
package lenet_loader_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int IMG_W_DEF      = 32;
  localparam int IMG_H_DEF      = 32;
  localparam int CLASS_W_DEF    = 4;
  localparam int RUN_CYCLES_DEF = 120000;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/lenet_run_timer.sv
// Run-window counter: counts 0..RUN_CYCLES-1 while enabled and pulses tc on the final count.
module lenet_run_timer
  import lenet_loader_pkg::*;
#(
  parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(RUN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc = en && (count_q == CNT_LAST);

  always_comb begin
    count_d = count_q;
    if (clr || tc) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lenet_frame_loader.sv
// Loads a raster pixel stream into the flat image bus, runs the network for a fixed window,
// and returns the captured class. Optional perf counters: define LENET_LOADER_PERF_EN.
//   state     | meaning
//   ST_LOAD   | accepting pixels, network held in reset
//   ST_RUN    | network out of reset, run window counting
//   ST_RESULT | class captured and offered on the result port
module lenet_frame_loader
  import lenet_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int RUN_CYCLES = RUN_CYCLES_DEF,
  parameter int CLASS_W    = CLASS_W_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_last,
  output logic [IMG_W*IMG_H*DATA_WIDTH-1:0] img_out,
  output logic                              lenet_rst,
  input  logic [CLASS_W-1:0]                class_in,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [CLASS_W-1:0]                res_class,
  output logic                              busy,
  output logic                              frame_err
`ifdef LENET_LOADER_PERF_EN
  ,
  output logic [15:0]                       frame_count,
  output logic [15:0]                       stall_count
`endif
);

  localparam int PIX_N = IMG_W * IMG_H;
  localparam int IDX_W = $clog2(PIX_N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIX_N - 1);

  state_e                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [PIX_N*DATA_WIDTH-1:0]       img_q, img_d;
  logic [CLASS_W-1:0]                res_class_q, res_class_d;
  logic                              frame_err_q, frame_err_d;
  logic                              run_tc;

  lenet_run_timer #(
    .RUN_CYCLES (RUN_CYCLES)
  ) u_run_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ST_RUN),
    .en    (state_q == ST_RUN),
    .tc    (run_tc)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    img_d       = img_q;
    res_class_d = res_class_q;
    frame_err_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          img_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = s_data;
          if (idx_q == IDX_LAST) begin
            // A missing end marker is flagged, but the full frame is still used.
            state_d     = ST_RUN;
            idx_d       = '0;
            frame_err_d = !s_last;
          end else if (s_last) begin
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (run_tc) begin
          res_class_d = class_in;
          state_d     = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      img_q       <= '0;
      res_class_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      img_q       <= img_d;
      res_class_q <= res_class_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign s_ready   = (state_q == ST_LOAD);
  assign lenet_rst = (state_q != ST_RUN);
  assign res_valid = (state_q == ST_RESULT);
  assign busy      = (state_q != ST_LOAD);
  assign img_out   = img_q;
  assign res_class = res_class_q;
  assign frame_err = frame_err_q;

`ifdef LENET_LOADER_PERF_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    stall_count_d = stall_count_q;
    if (state_q == ST_RESULT) begin
      if (res_ready) begin
        frame_count_d = frame_count_q + 16'd1;
      end else if (stall_count_q != 16'hFFFF) begin
        stall_count_d = stall_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
